// File: rtl/uart_echo_fifo.sv
// Buffered echo bridge: rising-edge captured receiver characters queue in a
// circular FIFO and are replayed to the transmitter via a start/busy handshake.
//
// state        | meaning
// -------------+--------------------------------------------------------
// ST_IDLE      | waiting for a queued character with hold released
// ST_START     | tx_start_o pulse; character already latched in tx_data_o
// ST_WAIT_BUSY | waiting for transmitter to acknowledge with busy
// ST_WAIT_DONE | transmitter busy; waiting for it to finish
module uart_echo_fifo #(
    parameter int P_DATA_W       = 7,
    parameter int P_ADDR_W       = 4,
    parameter int P_BUSY_TIMEOUT = 16,
    parameter int P_CNT_W        = 8
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                rx_data_ready_i,
    input  logic [P_DATA_W-1:0] rx_data_i,
    input  logic                parity_err_i,
    input  logic                framing_err_i,
    input  logic                tx_busy_i,
    output logic                tx_start_o,
    output logic [P_DATA_W-1:0] tx_data_o,
    input  logic                hold_i,
    input  logic                err_filter_i,
    input  logic                flush_i,
    output logic [P_ADDR_W:0]   fifo_count_o,
    output logic                fifo_empty_o,
    output logic                fifo_full_o,
    output logic                overflow_o,
    output logic [P_CNT_W-1:0]  drop_cnt_o,
    output logic [P_CNT_W-1:0]  timeout_cnt_o
);

    localparam int DEPTH = 2 ** P_ADDR_W;
    localparam int CNT_W = P_ADDR_W + 1;
    localparam int TMR_W = $clog2(P_BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);
    localparam logic [TMR_W-1:0]   TMR_LOAD = TMR_W'(P_BUSY_TIMEOUT - 1);
    localparam logic [P_CNT_W-1:0] SAT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 rdy_q, rdy_d;
    logic [P_ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [P_ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 empty_q, empty_d;
    logic                 full_q, full_d;
    logic                 overflow_q, overflow_d;
    logic [P_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [P_CNT_W-1:0]   timeout_cnt_q, timeout_cnt_d;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [P_DATA_W-1:0]  tx_data_q, tx_data_d;

    logic [P_DATA_W-1:0]  mem_q [DEPTH];

    logic push_req;
    logic err_drop;
    logic ovf_drop;
    logic wr_en;
    logic pop;

    // FIFO datapath and status
    always_comb begin
        push_req   = rx_data_ready_i & ~rdy_q;
        err_drop   = push_req & err_filter_i & (parity_err_i | framing_err_i);
        pop        = (state_q == ST_IDLE) & ~hold_i & (count_q != '0) & ~flush_i;
        ovf_drop   = push_req & ~err_drop & (count_q == FULL_CNT) & ~pop & ~flush_i;
        wr_en      = push_req & ~err_drop & ((count_q != FULL_CNT) | pop) & ~flush_i;

        rdy_d      = rx_data_ready_i;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (wr_en && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !wr_en) begin
                count_d = count_q - 1'b1;
            end
            if (ovf_drop) begin
                overflow_d = 1'b1;
            end
            if ((err_drop || ovf_drop) && (drop_cnt_q != SAT_MAX)) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == FULL_CNT);
    end

    // Transmit handshake FSM; busy timer counts down to a terminal zero
    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        tx_data_d     = tx_data_q;
        timeout_cnt_d = timeout_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    tx_data_d = mem_q[rd_ptr_q];
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                tmr_d   = TMR_LOAD;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy_i) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmr_q == '0) begin
                    state_d = ST_IDLE;
                    if (timeout_cnt_q != SAT_MAX) begin
                        timeout_cnt_d = timeout_cnt_q + 1'b1;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            rdy_q         <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            overflow_q    <= 1'b0;
            drop_cnt_q    <= '0;
            timeout_cnt_q <= '0;
            tmr_q         <= '0;
            tx_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            rdy_q         <= rdy_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            empty_q       <= empty_d;
            full_q        <= full_d;
            overflow_q    <= overflow_d;
            drop_cnt_q    <= drop_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            tmr_q         <= tmr_d;
            tx_data_q     <= tx_data_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= rx_data_i;
        end
    end

    assign tx_start_o    = (state_q == ST_START);
    assign tx_data_o     = tx_data_q;
    assign fifo_count_o  = count_q;
    assign fifo_empty_o  = empty_q;
    assign fifo_full_o   = full_q;
    assign overflow_o    = overflow_q;
    assign drop_cnt_o    = drop_cnt_q;
    assign timeout_cnt_o = timeout_cnt_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Self-checking bench for uart_echo_fifo: transaction-level queue model of the
// echo path, a transmitter model on the busy handshake, and randomized bursts.
module tb_uart_echo_fifo;

    localparam int DW    = 7;
    localparam int AW    = 4;
    localparam int TMO   = 16;
    localparam int CW    = 8;
    localparam int DEPTH = 2 ** AW;
    localparam int SAT   = 2 ** CW - 1;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          rx_data_ready_i;
    logic [DW-1:0] rx_data_i;
    logic          parity_err_i;
    logic          framing_err_i;
    logic          tx_busy_i;
    logic          tx_start_o;
    logic [DW-1:0] tx_data_o;
    logic          hold_i;
    logic          err_filter_i;
    logic          flush_i;
    logic [AW:0]   fifo_count_o;
    logic          fifo_empty_o;
    logic          fifo_full_o;
    logic          overflow_o;
    logic [CW-1:0] drop_cnt_o;
    logic [CW-1:0] timeout_cnt_o;

    uart_echo_fifo #(
        .P_DATA_W      (DW),
        .P_ADDR_W      (AW),
        .P_BUSY_TIMEOUT(TMO),
        .P_CNT_W       (CW)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .rx_data_ready_i(rx_data_ready_i),
        .rx_data_i      (rx_data_i),
        .parity_err_i   (parity_err_i),
        .framing_err_i  (framing_err_i),
        .tx_busy_i      (tx_busy_i),
        .tx_start_o     (tx_start_o),
        .tx_data_o      (tx_data_o),
        .hold_i         (hold_i),
        .err_filter_i   (err_filter_i),
        .flush_i        (flush_i),
        .fifo_count_o   (fifo_count_o),
        .fifo_empty_o   (fifo_empty_o),
        .fifo_full_o    (fifo_full_o),
        .overflow_o     (overflow_o),
        .drop_cnt_o     (drop_cnt_o),
        .timeout_cnt_o  (timeout_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    logic [DW-1:0] exp_q[$];
    int            exp_drop = 0;
    int            exp_tmo  = 0;
    int            exp_ovf  = 0;

    int  n_starts       = 0;
    int  last_start_cyc = 0;
    int  prev_start_cyc = 0;
    int  push_cyc       = 0;
    bit  tx_never_busy  = 1'b0;
    int  s0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    endtask

    task automatic drop_inc();
        if (exp_drop < SAT) exp_drop++;
    endtask

    task automatic model_push(input logic [DW-1:0] d, input bit err);
        if (err_filter_i && err) drop_inc();
        else if (exp_q.size() == DEPTH) begin
            exp_ovf = 1;
            drop_inc();
        end else exp_q.push_back(d);
    endtask

    task automatic push_char(input logic [DW-1:0] d, input bit pe, input bit fe);
        @(negedge clk_i);
        rx_data_i       = d;
        parity_err_i    = pe;
        framing_err_i   = fe;
        rx_data_ready_i = 1'b1;
        push_cyc        = cyc;
        model_push(d, pe | fe);
        @(negedge clk_i);
        rx_data_ready_i = 1'b0;
        parity_err_i    = 1'b0;
        framing_err_i   = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk_i);
        flush_i = 1'b1;
        exp_q.delete();
        exp_ovf = 0;
        @(negedge clk_i);
        flush_i = 1'b0;
    endtask

    task automatic drain();
        int quiet = 0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk_i);
            if (exp_q.size() == 0 && !tx_busy_i) quiet++;
            else quiet = 0;
            if (quiet > TMO + 4) break;
        end
        chk("drain_done", exp_q.size(), 0);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_count"}, int'(fifo_count_o), exp_q.size());
        chk({tag, "_empty"}, int'(fifo_empty_o), int'(exp_q.size() == 0));
        chk({tag, "_full"},  int'(fifo_full_o),  int'(exp_q.size() == DEPTH));
        chk({tag, "_ovf"},   int'(overflow_o),   exp_ovf);
        chk({tag, "_drop"},  int'(drop_cnt_o),   exp_drop);
        chk({tag, "_tmo"},   int'(timeout_cnt_o), exp_tmo);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_start"}, int'(tx_start_o),    0);
        chk({tag, "_data"},  int'(tx_data_o),     0);
        chk({tag, "_count"}, int'(fifo_count_o),  0);
        chk({tag, "_empty"}, int'(fifo_empty_o),  1);
        chk({tag, "_full"},  int'(fifo_full_o),   0);
        chk({tag, "_ovf"},   int'(overflow_o),    0);
        chk({tag, "_drop"},  int'(drop_cnt_o),    0);
        chk({tag, "_tmo"},   int'(timeout_cnt_o), 0);
    endtask

    // transmit monitor: every start must carry the oldest stored character
    initial begin
        forever begin
            @(negedge clk_i);
            if (tx_start_o) begin
                n_starts++;
                prev_start_cyc = last_start_cyc;
                last_start_cyc = cyc;
                chk("tx_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("tx_data", int'(tx_data_o), int'(exp_q.pop_front()));
            end
        end
    end

    // transmitter model: busy for 20 cycles after each start
    initial begin
        logic [DW-1:0] held;
        bit            saw_rst;
        tx_busy_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (tx_start_o && !tx_never_busy) begin
                held      = tx_data_o;
                saw_rst   = 1'b0;
                tx_busy_i = 1'b1;
                repeat (20) begin
                    @(negedge clk_i);
                    if (!rst_n_i) saw_rst = 1'b1;
                end
                tx_busy_i = 1'b0;
                if (!saw_rst) chk("tx_data_stable", int'(tx_data_o), int'(held));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i         = 1'b0;
        rx_data_ready_i = 1'b0;
        rx_data_i       = '0;
        parity_err_i    = 1'b0;
        framing_err_i   = 1'b0;
        hold_i          = 1'b0;
        err_filter_i    = 1'b0;
        flush_i         = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        check_reset("reset");

        // single echo and its latency
        s0 = n_starts;
        push_char(7'h41, 1'b0, 1'b0);
        drain();
        chk("echo_starts", n_starts - s0, 1);
        chk("echo_latency", last_start_cyc - push_cyc, 2);
        check_status("echo");

        // burst under hold, overflow, ordered drain, flush
        hold_i = 1'b1;
        for (int i = 1; i <= DEPTH; i++) push_char(DW'(i), 1'b0, 1'b0);
        check_status("burst_full");
        push_char(7'h55, 1'b0, 1'b0);
        check_status("overflow");
        s0 = n_starts;
        @(negedge clk_i);
        hold_i = 1'b0;
        drain();
        chk("burst_starts", n_starts - s0, DEPTH);
        chk("b2b_gap", last_start_cyc - prev_start_cyc, 22);
        check_status("burst_drained");
        do_flush();
        check_status("flush");

        // error filter on, then off
        err_filter_i = 1'b1;
        s0 = n_starts;
        push_char(7'h22, 1'b1, 1'b0);
        repeat (5) @(negedge clk_i);
        chk("efilt_no_start", n_starts - s0, 0);
        check_status("efilt_on");
        err_filter_i = 1'b0;
        push_char(7'h22, 1'b1, 1'b0);
        drain();
        chk("efilt_off_starts", n_starts - s0, 1);
        check_status("efilt_off");

        // busy timeout on two queued characters
        tx_never_busy = 1'b1;
        hold_i = 1'b1;
        push_char(7'h11, 1'b0, 1'b0);
        push_char(7'h12, 1'b0, 1'b0);
        s0 = n_starts;
        @(negedge clk_i);
        hold_i = 1'b0;
        drain();
        exp_tmo = 2;
        chk("tmo_starts", n_starts - s0, 2);
        chk("tmo_gap", last_start_cyc - prev_start_cyc, TMO + 2);
        check_status("timeout");
        tx_never_busy = 1'b0;

        // level held high yields one push
        hold_i = 1'b1;
        @(negedge clk_i);
        rx_data_i       = 7'h33;
        rx_data_ready_i = 1'b1;
        model_push(7'h33, 1'b0);
        repeat (100) @(negedge clk_i);
        rx_data_ready_i = 1'b0;
        @(negedge clk_i);
        check_status("level_hold");
        hold_i = 1'b0;
        drain();

        // flush discards queued characters
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) push_char(DW'($urandom_range(0, 127)), 1'b0, 1'b0);
        check_status("pre_flush");
        do_flush();
        check_status("post_flush");
        s0 = n_starts;
        hold_i = 1'b0;
        repeat (30) @(negedge clk_i);
        chk("flush_no_start", n_starts - s0, 0);

        // reset while the transmitter is busy
        push_char(7'h5a, 1'b0, 1'b0);
        for (int k = 0; k < 50 && !tx_busy_i; k++) @(negedge clk_i);
        chk("rst_busy_seen", int'(tx_busy_i), 1);
        repeat (2) @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        #1 check_reset("rst_mid");
        @(negedge clk_i);
        #2 rst_n_i = 1'b1;
        exp_q.delete();
        exp_drop = 0;
        exp_tmo  = 0;
        exp_ovf  = 0;
        s0 = n_starts;
        repeat (40) @(negedge clk_i);
        chk("rst_no_restart", n_starts - s0, 0);
        check_status("post_rst");

        // randomized bursts
        for (int r = 0; r < 6; r++) begin
            err_filter_i = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < int'($urandom_range(1, 8)); i++) begin
                push_char(DW'($urandom_range(0, 127)), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 5) == 0));
                repeat ($urandom_range(0, 4)) @(negedge clk_i);
            end
            drain();
            check_status("random");
        end

        // drop counter saturation
        err_filter_i = 1'b1;
        for (int i = 0; i < SAT + 5; i++) push_char(DW'(i), 1'b1, 1'b0);
        @(negedge clk_i);
        check_status("saturate");
        chk("saturate_max", int'(drop_cnt_o), SAT);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
